// File: rtl/commit_trace_tx_pkg.sv
// commit_trace_tx_pkg: record layout shared by the commit trace transmitter and its FIFO
// Provides the packed trace record (fields, widths and bit positions) and TRACE_REC_W.
// `MEM_ADDR_WIDTH normally comes from MIPS1000_defines.v; a 32-bit fallback keeps
// standalone builds complete. COMMIT_TRACE_CYCLE_EN adds a 32-bit capture-cycle field.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
package commit_trace_tx_pkg;
    localparam int PC_W       = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int MEM_ADDR_W = `MEM_ADDR_WIDTH;
    localparam int CYCLE_W    = 32;
    // Fields are listed MSB first, so each field's bit offset is the sum of the widths below it.
    typedef struct packed {
`ifdef COMMIT_TRACE_CYCLE_EN
        logic [CYCLE_W-1:0]    cycle;
`endif
        logic [PC_W-1:0]       pc;
        logic                  rf_we;
        logic [RF_ADDR_W-1:0]  rf_waddr;
        logic [DATA_W-1:0]     rf_wdata;
        logic                  mem_we;
        logic [BE_W-1:0]       mem_be;
        logic [MEM_ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0]     mem_wdata;
    } trace_rec_t;
    localparam int TRACE_REC_W = $bits(trace_rec_t);
endpackage

// File: rtl/commit_trace_tx_fifo.sv
// trace_fifo: generic synchronous FIFO with registered storage and wrap-bit pointers
// Ports: clk, rst (async active-low), push/wdata, pop, rdata (head entry), full, empty, count.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = wr_q == rd_q;
        full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        count   = wr_q - rd_q;
        rdata   = mem_q[rd_q[AW-1:0]];
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q[AW-1:0]] = wdata;
        wr_d    = wr_q + (AW+1)'(do_push);
        rd_d    = rd_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: captures retiring instructions as trace records and streams them out
// Inputs: commit_* / rf_* / mem_* retirement effects qualified by trace_en && commit_valid;
// tr_ready from the consumer. Outputs: tr_* record head (valid/ready), almost_full stall
// request, sticky overflow and saturating drop_cnt. Optional macro COMMIT_TRACE_CYCLE_EN
// adds tr_cycle, the free-running cycle count sampled at capture.
module commit_trace_tx
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int SEQ_W        = 16,
    parameter int DROP_W       = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       trace_en,
    input  logic                       commit_valid,
    input  logic [31:0]                commit_pc,
    input  logic                       rf_we,
    input  logic [4:0]                 rf_waddr,
    input  logic [31:0]                rf_wdata,
    input  logic                       mem_we,
    input  logic [3:0]                 mem_be,
    input  logic [`MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic                       tr_ready,
    output logic                       tr_valid,
    output logic [SEQ_W-1:0]           tr_seq,
    output logic [31:0]                tr_pc,
    output logic                       tr_rf_we,
    output logic [4:0]                 tr_rf_waddr,
    output logic [31:0]                tr_rf_wdata,
    output logic                       tr_mem_we,
    output logic [3:0]                 tr_mem_be,
    output logic [`MEM_ADDR_WIDTH-1:0] tr_mem_addr,
    output logic [31:0]                tr_mem_wdata,
`ifdef COMMIT_TRACE_CYCLE_EN
    output logic [31:0]                tr_cycle,
`endif
    output logic                       almost_full,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);
    localparam int W  = SEQ_W + TRACE_REC_W;
    localparam int CW = $clog2(DEPTH) + 1;

    trace_rec_t        rec, head;
    logic [W-1:0]      rdata;
    logic [CW-1:0]     count, count_next;
    logic              full, empty, capture, pop, push_ok, drop, rf_ok, mem_ok;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              almost_full_q, almost_full_d, overflow_q, overflow_d;

`ifdef COMMIT_TRACE_CYCLE_EN
    logic [31:0] cycle_q, cycle_d;
    assign cycle_d = cycle_q + 32'd1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycle_q <= '0;
        else      cycle_q <= cycle_d;
    end
    assign tr_cycle = head.cycle;
`endif

    always_comb begin
        capture         = trace_en && commit_valid;
        pop             = !empty && tr_ready;
        push_ok         = capture && (!full || pop);
        drop            = capture && full && !pop;
        // r0 writes and byte-less stores carry no architectural effect, so they are stored as absent.
        rf_ok           = rf_we && |rf_waddr;
        mem_ok          = mem_we && |mem_be;
        rec             = '0;
        rec.pc          = commit_pc;
        rec.rf_we       = rf_ok;
        rec.rf_waddr    = rf_ok ? rf_waddr : '0;
        rec.rf_wdata    = rf_ok ? rf_wdata : '0;
        rec.mem_we      = mem_ok;
        rec.mem_be      = mem_ok ? mem_be : '0;
        rec.mem_addr    = mem_ok ? mem_addr : '0;
        rec.mem_wdata   = mem_ok ? mem_wdata : '0;
`ifdef COMMIT_TRACE_CYCLE_EN
        rec.cycle       = cycle_q;
`endif
        count_next      = count + CW'(push_ok) - CW'(pop);
        // Dropped records still consume a sequence number so the consumer sees the gap.
        seq_d           = seq_q + SEQ_W'(capture);
        overflow_d      = overflow_q || drop;
        drop_cnt_d      = drop_cnt_q + DROP_W'(drop && !(&drop_cnt_q));
        almost_full_d   = count_next >= CW'(DEPTH - AFULL_MARGIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_q         <= '0;
            drop_cnt_q    <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            seq_q         <= seq_d;
            drop_cnt_q    <= drop_cnt_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    trace_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .wdata ({seq_q, rec}),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head         = rdata[TRACE_REC_W-1:0];
    assign tr_seq       = rdata[W-1 -: SEQ_W];
    assign tr_valid     = !empty;
    assign tr_pc        = head.pc;
    assign tr_rf_we     = head.rf_we;
    assign tr_rf_waddr  = head.rf_waddr;
    assign tr_rf_wdata  = head.rf_wdata;
    assign tr_mem_we    = head.mem_we;
    assign tr_mem_be    = head.mem_be;
    assign tr_mem_addr  = head.mem_addr;
    assign tr_mem_wdata = head.mem_wdata;
    assign almost_full  = almost_full_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: scoreboard bench for commit_trace_tx (DEPTH=8, SEQ_W=16)
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
module tb_commit_trace_tx;
    localparam int AW = `MEM_ADDR_WIDTH;

    typedef struct packed {
        logic [15:0]   seq;
        logic [31:0]   pc;
        logic          rf_we;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          mem_we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   mdata;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          trace_en = 1'b0, commit_valid = 1'b0, rf_we = 1'b0, mem_we = 1'b0, tr_ready = 1'b0;
    logic [31:0]   commit_pc = '0, rf_wdata = '0, mem_wdata = '0;
    logic [4:0]    rf_waddr = '0;
    logic [3:0]    mem_be = '0;
    logic [AW-1:0] mem_addr = '0;
    logic          tr_valid, tr_rf_we, tr_mem_we, almost_full, overflow;
    logic [15:0]   tr_seq, drop_cnt;
    logic [31:0]   tr_pc, tr_rf_wdata, tr_mem_wdata;
    logic [4:0]    tr_rf_waddr;
    logic [3:0]    tr_mem_be;
    logic [AW-1:0] tr_mem_addr;
`ifdef COMMIT_TRACE_CYCLE_EN
    logic [31:0]   tr_cycle;
    logic [31:0]   last_cyc = '0, prev_cyc = '0;
`endif

    int   checks = 0, errors = 0;
    rec_t exp_q[$];
    logic [15:0] mseq = '0;
    rec_t last;
    bit   held = 0;

    always #5 clk = ~clk;

    commit_trace_tx #(.DEPTH(8), .SEQ_W(16), .DROP_W(16), .AFULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .tr_ready(tr_ready), .tr_valid(tr_valid), .tr_seq(tr_seq), .tr_pc(tr_pc),
        .tr_rf_we(tr_rf_we), .tr_rf_waddr(tr_rf_waddr), .tr_rf_wdata(tr_rf_wdata),
        .tr_mem_we(tr_mem_we), .tr_mem_be(tr_mem_be), .tr_mem_addr(tr_mem_addr),
        .tr_mem_wdata(tr_mem_wdata),
`ifdef COMMIT_TRACE_CYCLE_EN
        .tr_cycle(tr_cycle),
`endif
        .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic rwe, input logic [4:0] wa,
                                input logic [31:0] wd, input logic mwe, input logic [3:0] be,
                                input logic [AW-1:0] ma, input logic [31:0] md);
        mk = '{seq: 16'h0, pc: pc, rf_we: rwe, waddr: wa, wdata: wd,
               mem_we: mwe, be: be, addr: ma, mdata: md};
    endfunction

    // Drive one commit for a single cycle; keep=1 queues the expected record with the model seq.
    task automatic commit(input rec_t raw, input rec_t expd, input bit keep);
        trace_en = 1'b1; commit_valid = 1'b1;
        commit_pc = raw.pc; rf_we = raw.rf_we; rf_waddr = raw.waddr; rf_wdata = raw.wdata;
        mem_we = raw.mem_we; mem_be = raw.be; mem_addr = raw.addr; mem_wdata = raw.mdata;
        @(posedge clk); #1;
        commit_valid = 1'b0;
        if (keep) begin
            expd.seq = mseq;
            exp_q.push_back(expd);
        end
        mseq++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every accepted record against the scoreboard, and check that a
    // stalled head holds every field stable.
    always @(negedge clk) begin
        rec_t cur;
        cur = '{seq: tr_seq, pc: tr_pc, rf_we: tr_rf_we, waddr: tr_rf_waddr, wdata: tr_rf_wdata,
                mem_we: tr_mem_we, be: tr_mem_be, addr: tr_mem_addr, mdata: tr_mem_wdata};
        if (!rst || !tr_valid) held = 0;
        else begin
            if (held) begin
                checks++;
                if (cur !== last) begin
                    errors++;
                    $display("FAIL hold: got %h expected %h", cur, last);
                end
            end
            if (tr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rec: got %h expected none", cur);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL rec: got %h expected %h", cur, e);
                    end
                end
`ifdef COMMIT_TRACE_CYCLE_EN
                prev_cyc = last_cyc;
                last_cyc = tr_cycle;
`endif
            end
            last = cur;
            held = !tr_ready;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        idle(2);
        chk("rst_valid", 64'(tr_valid), 64'd0);
        chk("rst_seq", 64'(tr_seq), 64'd0);
        chk("rst_pc", 64'(tr_pc), 64'd0);
        chk("rst_rf_wdata", 64'(tr_rf_wdata), 64'd0);
        chk("rst_mem_wdata", 64'(tr_mem_wdata), 64'd0);
        chk("rst_afull", 64'(almost_full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b1;
        tr_ready = 1'b1;
        idle(1);

        // Three spaced commits: tr_valid one cycle after each capture.
        for (int i = 0; i < 3; i++) begin
            r = mk(32'(i * 4), 1'b1, 5'd2, 32'h11, 1'b0, 4'h0, '0, 32'h0);
            chk("pre_valid", 64'(tr_valid), 64'd0);
            commit(r, r, 1'b1);
            chk("valid_latency", 64'(tr_valid), 64'd1);
            idle(1);
        end

        // Normalization: r0 write and byte-less store are stored as absent.
        commit(mk(32'h100, 1'b1, 5'd0, 32'hDEAD, 1'b0, 4'h0, '0, 32'h0),
               mk(32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0), 1'b1);
        commit(mk(32'h104, 1'b0, 5'd0, 32'h0, 1'b1, 4'h0, AW'(32'h40), 32'hBEEF),
               mk(32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0), 1'b1);
        r = mk(32'h108, 1'b1, 5'd31, 32'hCAFE0001, 1'b1, 4'hC, AW'(32'h80), 32'h12340000);
        commit(r, r, 1'b1);
        // trace_en low: no capture and no seq increment.
        trace_en = 1'b0; commit_valid = 1'b1; commit_pc = 32'h999;
        idle(1);
        commit_valid = 1'b0;
        drain();
        r = mk(32'h10C, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        commit(r, r, 1'b1);
        chk("trace_en_low_seq", 64'(tr_seq), 64'd6);
        drain();

        // Fresh reset, then overflow with the consumer stalled.
        rst = 1'b0; #1;
        exp_q.delete(); mseq = '0;
        idle(1);
        rst = 1'b1;
        tr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            r = mk(32'h1000 + 32'(i * 4), 1'b1, 5'(i + 1), 32'(i), 1'b0, 4'h0, '0, 32'h0);
            commit(r, r, i < 8);
            if (i == 4) chk("afull_after5", 64'(almost_full), 64'd0);
            if (i == 5) chk("afull_after6", 64'(almost_full), 64'd1);
            if (i == 7) chk("no_drop_at8", 64'(drop_cnt), 64'd0);
        end
        chk("overflow", 64'(overflow), 64'd1);
        chk("drop_cnt", 64'(drop_cnt), 64'd2);

        // Full FIFO with pop and push together: no drop, count stays at DEPTH.
        tr_ready = 1'b1;
        r = mk(32'h2000, 1'b0, 5'd0, 32'h0, 1'b1, 4'h3, AW'(32'h55), 32'h0000ABCD);
        commit(r, r, 1'b1);
        chk("full_pop_push_drop", 64'(drop_cnt), 64'd2);
        chk("full_pop_push_afull", 64'(almost_full), 64'd1);
        tr_ready = 1'b0;
        idle(3);
        chk("stall_head_seq", 64'(tr_seq), 64'd1);
        tr_ready = 1'b1;
        drain();
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Seq wrap at 0xFFFF.
        while (mseq != 16'hFFFF) begin
            r = mk({16'h0, mseq}, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
            commit(r, r, 1'b1);
        end
        r = mk(32'h3000, 1'b1, 5'd7, 32'h77, 1'b0, 4'h0, '0, 32'h0);
        commit(r, r, 1'b1);
        chk("seq_ffff", 64'(tr_seq), 64'hFFFF);
        r = mk(32'h3004, 1'b1, 5'd8, 32'h88, 1'b0, 4'h0, '0, 32'h0);
        commit(r, r, 1'b1);
        chk("seq_wrap", 64'(tr_seq), 64'h0);
        drain();

        // Reset mid-drain with 4 records queued.
        tr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = mk(32'h4000 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
            commit(r, r, 1'b1);
        end
        chk("queued_valid", 64'(tr_valid), 64'd1);
        rst = 1'b0; #1;
        chk("midrst_valid", 64'(tr_valid), 64'd0);
        chk("midrst_overflow", 64'(overflow), 64'd0);
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete(); mseq = '0;
        idle(1);
        rst = 1'b1;
        tr_ready = 1'b1;
        r = mk(32'h5000, 1'b1, 5'd3, 32'h33, 1'b0, 4'h0, '0, 32'h0);
        commit(r, r, 1'b1);
        chk("post_rst_seq", 64'(tr_seq), 64'd0);
        drain();

`ifdef COMMIT_TRACE_CYCLE_EN
        r = mk(32'h6000, 1'b0, 5'd0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        commit(r, r, 1'b1);
        idle(2);
        commit(r, r, 1'b1);
        drain();
        chk("cycle_spacing", 64'(last_cyc - prev_cyc), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/commit_trace_tx.md
Name: commit_trace_tx

Overview:
- Retirement-side trace transmitter inside the RTL processor. Captures each committed instruction's architectural effects: PC, register-file writeback and store.
- Buffers each commit as a record in a FIFO and transmits it over a valid/ready interface to a lockstep checker or logger.
- Gives the checker explicit per-instruction records instead of hierarchical probing. Also supplies early backpressure to the pipeline.

Parameters:
- DEPTH, 8: FIFO entries; power of two, minimum 4.
- SEQ_W, 16: width of the commit sequence number.
- DROP_W, 16: width of the saturating dropped-record counter.
- AFULL_MARGIN, 2: almost_full asserts when count >= DEPTH-AFULL_MARGIN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- trace_en  in  1  capture enable; when low, commits are ignored and not counted.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  32  PC of the retiring instruction.
- rf_we  in  1  register writeback.
- rf_waddr  in  5  writeback register.
- rf_wdata  in  32  writeback data.
- mem_we  in  1  store.
- mem_be  in  4  store byte enables.
- mem_addr  in  `MEM_ADDR_WIDTH  store word address.
- mem_wdata  in  32  store data, byte-lane aligned.
- tr_valid  out  1  record available.
- tr_ready  in  1  consumer accepts the record.
- tr_seq  out  SEQ_W  commit sequence number.
- tr_pc  out  32  record PC.
- tr_rf_we  out  1  record writeback flag.
- tr_rf_waddr  out  5  record writeback register.
- tr_rf_wdata  out  32  record writeback data.
- tr_mem_we  out  1  record store flag.
- tr_mem_be  out  4  record byte enables.
- tr_mem_addr  out  `MEM_ADDR_WIDTH  record store address.
- tr_mem_wdata  out  32  record store data.
- almost_full  out  1  stall request to the pipeline.
- overflow  out  1  sticky; at least one record was dropped.
- drop_cnt  out  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; tr_valid=0; all tr_* data outputs 0.
  - seq counter=0; almost_full=0; overflow=0; drop_cnt=0.
- Capture: a commit is captured when trace_en && commit_valid.
- Record normalization at capture:
  - rf_we && rf_waddr==0 → stored rf_we=0, waddr=0, wdata=0 (r0 is not architectural state).
  - mem_we && mem_be==0 → stored mem_we=0.
  - When a flag is stored as 0, its data fields are stored as 0.
- Sequence numbering:
  - Each captured commit is assigned the current seq, then seq increments.
  - seq increments even if the record is dropped, so the consumer detects the gap.
  - seq wraps from 2^SEQ_W-1 to 0.
- Push/pop:
  - Push accepted if the FIFO is not full, or a pop occurs the same cycle.
  - Pop = tr_valid && tr_ready.
  - Full with pop and push in the same cycle → both happen; count unchanged; no drop.
- Drop: capture while full with no pop →
  - record discarded;
  - overflow set (stays set until reset);
  - drop_cnt increments, saturating at all-ones.
- Latency:
  - A push into an empty FIFO makes tr_valid=1 on the next cycle.
  - Outputs are driven from the FIFO head register; no combinational path from commit_* to tr_*.
- Handshake rules:
  - While tr_valid=1 && tr_ready=0, all tr_* outputs hold stable.
  - tr_valid never deasserts without a pop.
  - tr_ready while tr_valid=0 has no effect.
- almost_full: registered; reflects the post-update count, i.e. (count_next >= DEPTH-AFULL_MARGIN).
- trace_en low: no capture, no seq increment. The FIFO continues to drain.
- Wrap-around: read and write pointers are log2(DEPTH) bits wide, plus an extra wrap bit for full/empty detection.
- Reset mid-transfer: all buffered records are lost. The consumer must resynchronize on seq==0.

Optional Feature:
- Macro: COMMIT_TRACE_CYCLE_EN.
- Defined:
  - Adds output tr_cycle[31:0] and a free-running 32-bit cycle counter (reset 0, wraps).
  - Each record stores the counter value at its capture cycle.
  - tr_cycle obeys the same stability rule as the other tr_* outputs.
- Undefined: no port, no counter; record width excludes the field.

Decomposition:
- Shared package (`include):
  - record field widths and bit offsets of the packed record vector;
  - use the existing `MEM_ADDR_WIDTH from MIPS1000_defines.v;
  - TRACE_REC_W, computed with and without COMMIT_TRACE_CYCLE_EN.
- Sub-module trace_fifo:
  - generic synchronous FIFO, parameterized by WIDTH and DEPTH;
  - clk, rst as above;
  - push/pop/full/empty/count ports.
- commit_trace_tx holds: normalization, seq counter, drop logic, record pack/unpack, optional cycle counter.

Test Plan:
- Reset, then 3 commits (pc 0x0, 0x4, 0x8; rf_we to r2=0x11) with tr_ready=1 → tr_valid rises 1 cycle after each commit; seq 0,1,2; pc and wdata match.
- Commit with rf_we=1, rf_waddr=0, wdata=0xDEAD; and a commit with mem_we=1, mem_be=0 → stored record shows tr_rf_we=0, wdata=0, tr_mem_we=0.
- tr_ready=0, 10 back-to-back commits, DEPTH=8:
  - almost_full rises after the 6th push;
  - records 9-10 dropped; overflow=1; drop_cnt=2;
  - draining yields seq 0..7; next commit carries seq 10.
- FIFO full with tr_ready=1 and commit_valid=1 in the same cycle → no drop; count stays 8; tr_* held stable through a 3-cycle ready stall.
- Drive seq to 0xFFFF and commit twice → seq 0xFFFF then 0x0000.
- Assert rst low mid-drain (4 records queued) → tr_valid=0 immediately; next commit after release reports seq 0.
- With COMMIT_TRACE_CYCLE_EN defined → tr_cycle differences equal the commit spacing.
